// File: rtl/switch_debouncer.sv
// switch_debouncer: synchronises a raw switch bank to clk and debounces each
// bit on a shared prescaled sample tick.
//
// Ports:
//   clk          system clock
//   reset_n      asynchronous active-low reset, clears every register
//   sw_raw       raw asynchronous switch levels
//   change_clr   synchronous clear of change_flag
//   sw_stable    debounced levels (feeds the iobuffer input port)
//   sw_rise      one-cycle pulse per bit on an accepted 0->1
//   sw_fall      one-cycle pulse per bit on an accepted 1->0
//   change_flag  sticky: any accepted edge since the last clear
module switch_debouncer #(
  parameter int WIDTH          = 32,
  parameter int TICK_DIV       = 1000,
  parameter int STABLE_SAMPLES = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] sw_raw,
  input  logic             change_clr,
  output logic [WIDTH-1:0] sw_stable,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall,
  output logic             change_flag
);

  localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);

  typedef logic [STABLE_SAMPLES-1:0] hist_t;

  logic [WIDTH-1:0] sync1_q, sync1_d;
  logic [WIDTH-1:0] sync2_q, sync2_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  hist_t [WIDTH-1:0] hist_q, hist_d;
  logic [WIDTH-1:0] stable_q, stable_d;
  logic [WIDTH-1:0] rise_q, rise_d;
  logic [WIDTH-1:0] fall_q, fall_d;
  logic             flag_q, flag_d;
  logic             tick;

  assign tick = (cnt_q == CNT_LAST);

  always_comb begin
    sync1_d  = sw_raw;
    sync2_d  = sync1_q;
    cnt_d    = tick ? '0 : cnt_q + 1'b1;
    hist_d   = hist_q;
    stable_d = stable_q;
    rise_d   = '0;
    fall_d   = '0;
    if (tick) begin
      for (int i = 0; i < WIDTH; i++) begin
        hist_d[i] = {hist_q[i][STABLE_SAMPLES-2:0], sync2_q[i]};
        // Acceptance looks at the history including this tick's sample.
        if (&hist_d[i] && !stable_q[i]) begin
          stable_d[i] = 1'b1;
          rise_d[i]   = 1'b1;
        end else if (~|hist_d[i] && stable_q[i]) begin
          stable_d[i] = 1'b0;
          fall_d[i]   = 1'b1;
        end
      end
    end
    // A new edge beats a simultaneous clear.
    if ((|rise_d) || (|fall_d)) begin
      flag_d = 1'b1;
    end else if (change_clr) begin
      flag_d = 1'b0;
    end else begin
      flag_d = flag_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      cnt_q    <= '0;
      hist_q   <= '0;
      stable_q <= '0;
      rise_q   <= '0;
      fall_q   <= '0;
      flag_q   <= 1'b0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      cnt_q    <= cnt_d;
      hist_q   <= hist_d;
      stable_q <= stable_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      flag_q   <= flag_d;
    end
  end

  assign sw_stable   = stable_q;
  assign sw_rise     = rise_q;
  assign sw_fall     = fall_q;
  assign change_flag = flag_q;

endmodule

// File: tb/tb_switch_debouncer.sv
// tb_switch_debouncer: directed and random stimulus for switch_debouncer,
// checked every cycle against a run-length behavioural model.
module tb_switch_debouncer;

  localparam int W  = 32;
  localparam int TD = 4;
  localparam int SS = 3;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [W-1:0]  sw_raw = '0;
  logic          change_clr = 1'b0;
  logic [W-1:0]  sw_stable, sw_rise, sw_fall;
  logic          change_flag;

  int total = 0;
  int bad = 0;

  switch_debouncer #(
    .WIDTH(W), .TICK_DIV(TD), .STABLE_SAMPLES(SS)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .sw_raw(sw_raw),
    .change_clr(change_clr),
    .sw_stable(sw_stable),
    .sw_rise(sw_rise),
    .sw_fall(sw_fall),
    .change_flag(change_flag)
  );

  always #5 clk = ~clk;

  // Model: raw goes through a 2-deep delay line; every TD-th edge since
  // reset samples it. A bit is accepted once the run of identical samples
  // reaches SS and differs from the current stable level.
  logic [W-1:0] m_s1, m_s2, m_stable, m_rise, m_fall;
  bit           m_flag;
  int           m_cyc;
  int           run [W];
  bit           last [W];

  task automatic m_reset();
    m_s1 = '0; m_s2 = '0; m_stable = '0;
    m_rise = '0; m_fall = '0; m_flag = 0; m_cyc = 0;
    for (int i = 0; i < W; i++) begin
      run[i] = SS;
      last[i] = 1'b0;
    end
  endtask

  initial begin
    m_reset();
    forever begin
      logic [W-1:0] samp;
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        m_reset();
      end else begin
        samp = m_s2;
        m_rise = '0;
        m_fall = '0;
        m_cyc++;
        if (m_cyc % TD == 0) begin
          for (int i = 0; i < W; i++) begin
            if (samp[i] == last[i]) begin
              if (run[i] < SS) run[i]++;
            end else begin
              last[i] = samp[i];
              run[i] = 1;
            end
            if (run[i] >= SS && last[i] != m_stable[i]) begin
              m_stable[i] = last[i];
              if (last[i]) m_rise[i] = 1'b1;
              else m_fall[i] = 1'b1;
            end
          end
        end
        if ((m_rise | m_fall) != '0) m_flag = 1;
        else if (change_clr) m_flag = 0;
        m_s2 = m_s1;
        m_s1 = sw_raw;
      end
    end
  end

  task automatic chk(input string nm, input logic [W-1:0] act,
                     input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%h want=%h", nm, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    chk("stable", sw_stable, m_stable);
    chk("rise", sw_rise, m_rise);
    chk("fall", sw_fall, m_fall);
    chk("flag", {31'b0, change_flag}, {31'b0, m_flag});
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset(input int hold);
    @(negedge clk);
    #2 reset_n = 1'b0;
    step(hold);
    #2 reset_n = 1'b1;
  endtask

  // Align so that the next raw change is accepted exactly 12 edges later.
  task automatic align();
    while (m_cyc % TD != 0) step(1);
  endtask

  initial begin
    logic [W-1:0] keep;
    bit seen;
    // Scenario 1: bit 0 high through reset.
    sw_raw = 32'h1;
    step(3);
    #2 reset_n = 1'b1;
    step(11);
    chk("pin_e11_stable", sw_stable, 32'h0);
    step(1);
    chk("pin_e12_stable", sw_stable, 32'h1);
    chk("pin_e12_rise", sw_rise, 32'h1);
    chk("pin_e12_flag", {31'b0, change_flag}, 32'h1);
    step(1);
    chk("pin_e13_rise", sw_rise, 32'h0);
    change_clr = 1'b1;
    step(1);
    change_clr = 1'b0;

    // Glitch on bit 3 from an all-zero stable state.
    sw_raw = '0;
    step(20);
    change_clr = 1'b1;
    step(1);
    change_clr = 1'b0;
    sw_raw = 32'h8;
    step(6);
    sw_raw = '0;
    step(20);
    chk("pin_glitch_stable", sw_stable, 32'h0);
    chk("pin_glitch_flag", {31'b0, change_flag}, 32'h0);

    // 0x0F -> 0xF0 on a single edge.
    sw_raw = 32'h0F;
    step(20);
    align();
    sw_raw = 32'hF0;
    step(12);
    chk("pin_swap_stable", sw_stable, 32'hF0);
    chk("pin_swap_rise", sw_rise, 32'hF0);
    chk("pin_swap_fall", sw_fall, 32'h0F);
    step(1);
    chk("pin_swap_pulse", sw_rise | sw_fall, 32'h0);

    // Clear coinciding with an accepting edge loses to the set.
    align();
    sw_raw = 32'hF1;
    step(11);
    change_clr = 1'b1;
    step(1);
    change_clr = 1'b0;
    chk("pin_clr_race_rise", sw_rise, 32'h1);
    chk("pin_clr_race_flag", {31'b0, change_flag}, 32'h1);
    change_clr = 1'b1;
    step(1);
    change_clr = 1'b0;
    chk("pin_clr_flag", {31'b0, change_flag}, 32'h0);

    // Bit 0 chatters on successive ticks.
    sw_raw = '0;
    step(20);
    align();
    keep = sw_stable;
    for (int t = 0; t < 20; t++) begin
      sw_raw[0] = ~sw_raw[0];
      step(TD);
    end
    chk("pin_chatter_stable", sw_stable, keep);

    // Mid-operation reset with all bits high.
    sw_raw = '1;
    step(20);
    chk("pin_all_high", sw_stable, 32'hFFFF_FFFF);
    do_reset(1);
    chk("pin_rst_stable", sw_stable, 32'h0);
    chk("pin_rst_fall", sw_fall, 32'h0);
    step(11);
    chk("pin_rst_e11", sw_stable, 32'h0);
    step(1);
    chk("pin_rst_e12_stable", sw_stable, 32'hFFFF_FFFF);
    chk("pin_rst_e12_rise", sw_rise, 32'hFFFF_FFFF);

    // Bounded wait for a rise after a clean transition.
    sw_raw = '0;
    step(20);
    sw_raw = 32'h8000_0000;
    seen = 0;
    for (int c = 0; c < 2 + SS * TD + 2 && !seen; c++) begin
      step(1);
      if (sw_rise != '0) seen = 1;
    end
    chk("pin_latency_seen", {31'b0, seen}, 32'h1);

    // Random phase: slowly-changing and chattering bits, random clears.
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 5) == 0)
        sw_raw[$urandom_range(0, W - 1)] ^= 1'b1;
      if ($urandom_range(0, 1) == 0)
        sw_raw[$urandom_range(0, 3)] ^= 1'b1;
      if ($urandom_range(0, 30) == 0)
        sw_raw = $urandom;
      change_clr = ($urandom_range(0, 15) == 0);
      if (c == 700) begin
        change_clr = 1'b0;
        do_reset(2);
      end
    end
    change_clr = 1'b0;
    step(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/switch_debouncer.md
Name: switch_debouncer

Overview:
- Input conditioner directly upstream of the I/O buffer's input port (PORT_A): takes the raw board switch bank, synchronises it to clk and debounces each bit by sampling it on a shared prescaled tick.
- Presents a stable vector to the I/O buffer, plus per-bit edge pulses and a sticky change flag for polled firmware.
- One instance per switch bank; sits between the board pins and the iobuffer.

Parameters:
- WIDTH, 32, number of switch bits (1..32).
- TICK_DIV, 1000, clk cycles per sample tick (>=2).
- STABLE_SAMPLES, 4, consecutive equal samples required to accept a new level (>=2).

Ports:
- clk  input  1  system clock (PLL output).
- reset_n  input  1  asynchronous active-low reset.
- sw_raw  input  WIDTH  raw asynchronous switch levels.
- change_clr  input  1  synchronous clear of change_flag.
- sw_stable  output  WIDTH  debounced levels; drives iobuffer PORT_A.
- sw_rise  output  WIDTH  one-cycle pulse per bit on accepted 0->1.
- sw_fall  output  WIDTH  one-cycle pulse per bit on accepted 1->0.
- change_flag  output  1  sticky: any accepted edge since the last clear.

Behaviour:
- Reset is asynchronous and active-low: while reset_n=0, every register is 0. This covers the sync stages, prescaler, history, sw_stable, sw_rise, sw_fall and change_flag.
- Reset release never generates an edge pulse, even with inputs high.
- Synchroniser: a 2-flop chain per bit. sync_out is the second flop and reflects sw_raw after 2 clk edges.
- Prescaler:
  - Counter runs 0..TICK_DIV-1 and wraps to 0.
  - tick is combinational, high while count==TICK_DIV-1.
  - After reset, the first tick-qualified edge is edge number TICK_DIV.
- History: a per-bit shift register of STABLE_SAMPLES bits.
  - On each tick edge: hist <= {hist[STABLE_SAMPLES-2:0], sync_out}.
  - With no tick, hist holds.
- Acceptance, on the same tick edge, using the new history value:
  - New hist all ones and sw_stable[i]=0: sw_stable[i]<=1 and sw_rise[i]<=1.
  - New hist all zeros and sw_stable[i]=1: sw_stable[i]<=0 and sw_fall[i]<=1.
  - Otherwise sw_stable[i] holds. Mixed history never changes the output.
- sw_rise and sw_fall are registered and high for exactly one cycle, cleared on every other edge.
- Bits are fully independent: rises and falls on different bits in the same tick produce both masks simultaneously.
- change_flag:
  - Set on any edge that writes a nonzero sw_rise or sw_fall.
  - Cleared on an edge with change_clr=1.
  - Set wins when both happen on the same edge.
- Acceptance latency from a clean sw_raw transition: min 2+(STABLE_SAMPLES-1)*TICK_DIV+1, max 2+STABLE_SAMPLES*TICK_DIV clk cycles.
- Glitch rejection: a level held for fewer than STABLE_SAMPLES consecutive ticks is never accepted.
- Reset mid-operation:
  - Aborts partial histories and pulses.
  - After release, sw_stable re-acquires from 0 with the full latency.

Test Plan (TICK_DIV=4, STABLE_SAMPLES=3, WIDTH=32 unless stated):
- sw_raw=0x00000001 held through reset, then released:
  - ticks fall at edges 4, 8 and 12.
  - At edge 12: sw_stable=0x00000001, sw_rise=0x00000001 for one cycle, change_flag=1.
  - No pulses at any other edge.
- Glitch: bit 3 driven high for 6 cycles, then low, starting from an all-0 stable state -> sw_stable, sw_rise and change_flag stay 0 throughout.
- From sw_stable=0x0000000F, set sw_raw=0x000000F0 and hold -> the same edge gives:
  - sw_stable=0x000000F0
  - sw_rise=0x000000F0
  - sw_fall=0x0000000F
  - each pulse lasting one cycle.
- change_clr=1 on the exact edge that accepts a new rise -> change_flag=1 afterwards. change_clr=1 one cycle later -> change_flag=0.
- Bit 0 chatters 1,0,1,0 on successive ticks for 20 ticks -> sw_stable[0] never changes, with no sw_rise or sw_fall pulses.
- With sw_stable=0xFFFFFFFF, pulse reset_n low for 1 cycle while sw_raw=0xFFFFFFFF:
  - All outputs are 0 during and right after reset, with no sw_fall pulse.
  - sw_stable returns to 0xFFFFFFFF at edge 12 after release, with sw_rise=0xFFFFFFFF.
